// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = $clog2(LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          f_done_q, f_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          owner;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    en_d      = en_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_done_d  = 1'b0;
    d_done_d  = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    busy_d    = busy_q;
    owner     = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // On conflict the side that did not win last time goes first.
          owner   = (f_req && d_req) ? ~last_q : d_req;
          sel_d   = owner;
          addr_d  = owner ? d_addr : f_addr;
          wdata_d = owner ? d_wdata : wdata_q;
          we_d    = owner & d_we;
          last_d  = owner;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) begin
            if (sel_q) d_rdata_d = mem_rdata;
            else       f_rdata_d = mem_rdata;
          end
          en_d     = 1'b0;
          we_d     = 1'b0;
          f_done_d = ~sel_q;
          d_done_d = sel_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign f_done    = f_done_q;
  assign f_rdata   = f_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_sel   = sel_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at LAT=1 and LAT=3
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic fa_req, fa_done, da_req, da_we, da_done, ma_sel, ma_en, ma_we, a_busy;
  logic [31:0] fa_addr, fa_rdata, da_addr, da_wdata, da_rdata, ma_addr, ma_wdata, ma_rdata;
  logic fb_req, fb_done, db_req, db_we, db_done, mb_sel, mb_en, mb_we, b_busy;
  logic [31:0] fb_addr, fb_rdata, db_addr, db_wdata, db_rdata, mb_addr, mb_wdata, mb_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .f_req(fa_req), .f_addr(fa_addr), .f_done(fa_done), .f_rdata(fa_rdata),
    .d_req(da_req), .d_we(da_we), .d_addr(da_addr), .d_wdata(da_wdata),
    .d_done(da_done), .d_rdata(da_rdata),
    .mem_sel(ma_sel), .mem_en(ma_en), .mem_we(ma_we), .mem_addr(ma_addr),
    .mem_wdata(ma_wdata), .mem_rdata(ma_rdata), .busy(a_busy));

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .f_req(fb_req), .f_addr(fb_addr), .f_done(fb_done), .f_rdata(fb_rdata),
    .d_req(db_req), .d_we(db_we), .d_addr(db_addr), .d_wdata(db_wdata),
    .d_done(db_done), .d_rdata(db_rdata),
    .mem_sel(mb_sel), .mem_en(mb_en), .mem_we(mb_we), .mem_addr(mb_addr),
    .mem_wdata(mb_wdata), .mem_rdata(mb_rdata), .busy(b_busy));

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(idx);
  endfunction

  // Memory models: data is only valid in the last ACCESS cycle, garbage otherwise.
  bit          wv_a [64];
  bit [31:0]   wd_a [64];
  bit          wv_b [64];
  bit [31:0]   wd_b [64];
  int          acc_a = 0;
  int          acc_b = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    acc_a <= ma_en ? acc_a + 1 : 0;
    acc_b <= mb_en ? acc_b + 1 : 0;
    if (ma_en && ma_we) begin wv_a[ma_addr[7:2]] <= 1'b1; wd_a[ma_addr[7:2]] <= ma_wdata; end
    if (mb_en && mb_we) begin wv_b[mb_addr[7:2]] <= 1'b1; wd_b[mb_addr[7:2]] <= mb_wdata; end
  end

  assign ma_rdata = (ma_en && acc_a == 0) ?
    (wv_a[ma_addr[7:2]] ? wd_a[ma_addr[7:2]] : init_word(int'(ma_addr[7:2]))) : 32'hBAD0BAD0;
  assign mb_rdata = (mb_en && acc_b == 2) ?
    (wv_b[mb_addr[7:2]] ? wd_b[mb_addr[7:2]] : init_word(int'(mb_addr[7:2]))) : 32'hBAD0BAD0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int port; logic owner; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   ndone    = 0;
  int   done_cyc = -1;

  task automatic push(input int port, input logic owner, input logic [31:0] data);
    exp_t e;
    e.port = port; e.owner = owner; e.data = data;
    sb.push_back(e);
  endtask

  task automatic observe(input int port, input logic fd, input logic dd,
                         input logic [31:0] fr, input logic [31:0] dr);
    exp_t e;
    check("done_exclusive", 32'(fd & dd), 32'd0);
    if (fd || dd) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_port", 32'(port), 32'(e.port));
        check("sb_owner", 32'(dd), 32'(e.owner));
        check("sb_rdata", dd ? dr : fr, e.data);
      end
      ndone++;
      done_cyc = cyc;
    end
  endtask

  always @(negedge clk) begin
    observe(0, fa_done, da_done, fa_rdata, da_rdata);
    observe(1, fb_done, db_done, fb_rdata, db_rdata);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int target, input int limit);
    int k = 0;
    while (ndone < target && k < limit) begin
      tick();
      k++;
    end
    check(tag, 32'(ndone), 32'(target));
  endtask

  int c0;
  int n0;

  initial begin
    fa_req = 0; fa_addr = 0; da_req = 0; da_we = 0; da_addr = 0; da_wdata = 0;
    fb_req = 0; fb_addr = 0; db_req = 0; db_we = 0; db_addr = 0; db_wdata = 0;
    tick(); tick();
    check("rst_a_en", 32'(ma_en), 0);
    check("rst_a_we", 32'(ma_we), 0);
    check("rst_a_sel", 32'(ma_sel), 0);
    check("rst_a_addr", ma_addr, 0);
    check("rst_a_wdata", ma_wdata, 0);
    check("rst_a_busy", 32'(a_busy), 0);
    check("rst_a_frdata", fa_rdata, 0);
    check("rst_a_drdata", da_rdata, 0);
    check("rst_b_busy", 32'(b_busy), 0);
    rst = 0;
    tick();

    // Single fetch at LAT=1.
    c0 = cyc; fa_addr = 32'h10; fa_req = 1; push(0, 1'b0, 32'hDEADBEEF);
    tick();
    check("t1_en", 32'(ma_en), 1);
    check("t1_sel", 32'(ma_sel), 0);
    check("t1_addr", ma_addr, 32'h10);
    check("t1_we", 32'(ma_we), 0);
    tick();
    check("t1_done_cyc", 32'(done_cyc), 32'(c0 + 2));
    check("t1_en_resp", 32'(ma_en), 0);
    fa_req = 0;
    tick();
    check("t1_idle_busy", 32'(a_busy), 0);

    // Simultaneous requests right after reset: F first, then D.
    rst = 1; tick(); rst = 0; tick();
    c0 = cyc; fa_addr = 32'h14; da_addr = 32'h18; da_we = 0; fa_req = 1; da_req = 1;
    push(0, 1'b0, init_word(5)); push(0, 1'b1, init_word(6));
    tick();
    check("t2_sel_f", 32'(ma_sel), 0);
    tick();
    check("t2_fdone_cyc", 32'(done_cyc), 32'(c0 + 2));
    fa_req = 0;
    tick(); tick();
    check("t2_sel_d", 32'(ma_sel), 1);
    tick();
    check("t2_ddone_cyc", 32'(done_cyc), 32'(c0 + 5));
    da_req = 0;
    tick();

    // Both held for six transfers: strict F/D alternation.
    fa_addr = 32'h20; da_addr = 32'h24;
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, init_word(8)); push(0, 1'b1, init_word(9));
    end
    n0 = ndone; fa_req = 1; da_req = 1;
    wait_done("t3_six_done", n0 + 6, 40);
    fa_req = 0; da_req = 0;
    tick(); tick();
    check("t3_idle_busy", 32'(a_busy), 0);

    // LAT=3: load to give d_rdata a known value, then a store.
    db_addr = 32'h30; db_we = 0; db_req = 1; push(1, 1'b1, init_word(12));
    wait_done("t4_load", ndone + 1, 20);
    db_req = 0;
    tick();
    c0 = cyc; db_addr = 32'h20; db_wdata = 32'h12345678; db_we = 1; db_req = 1;
    push(1, 1'b1, init_word(12));
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t4_we", 32'(mb_we), 1);
      check("t4_en", 32'(mb_en), 1);
      check("t4_addr", mb_addr, 32'h20);
      check("t4_wdata", mb_wdata, 32'h12345678);
    end
    tick();
    check("t4_done_cyc", 32'(done_cyc), 32'(c0 + 4));
    check("t4_we_resp", 32'(mb_we), 0);
    db_req = 0; db_we = 0;
    tick();
    db_req = 1; push(1, 1'b1, 32'h12345678);
    wait_done("t4_readback", ndone + 1, 20);
    db_req = 0;
    tick();

    // Payload change after grant is ignored.
    c0 = cyc; db_addr = 32'h40; db_req = 1; push(1, 1'b1, init_word(16));
    tick();
    check("t5_addr1", mb_addr, 32'h40);
    db_addr = 32'h44;
    tick();
    check("t5_addr2", mb_addr, 32'h40);
    tick();
    check("t5_addr3", mb_addr, 32'h40);
    tick();
    check("t5_done_cyc", 32'(done_cyc), 32'(c0 + 4));
    db_req = 0;
    tick();

    // Reset in the second ACCESS cycle aborts with no done pulse.
    fb_addr = 32'h10; fb_req = 1;
    tick(); tick();
    rst = 1; #1;
    check("t6_en", 32'(mb_en), 0);
    check("t6_busy", 32'(b_busy), 0);
    check("t6_addr", mb_addr, 0);
    check("t6_drdata", db_rdata, 0);
    check("t6_fdone", 32'(fb_done), 0);
    fb_req = 0;
    tick();
    rst = 0; n0 = ndone;
    for (int i = 0; i < 4; i++) tick();
    check("t6_no_done", 32'(ndone), 32'(n0));
    c0 = cyc; fb_req = 1; push(1, 1'b0, 32'hDEADBEEF);
    wait_done("t6_regrant", n0 + 1, 20);
    check("t6_done_cyc", 32'(done_cyc), 32'(c0 + 4));
    fb_req = 0;
    tick(); tick();
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
